// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V hazard unit: address width, forward
// select encodings, stall counter width and a source/destination match helper.
package riscv_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int STALL_CNT_W = 16;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // A source matches a destination only when both name the same register and
    // that register is not x0, which is hard-wired to zero and never produced.
    function automatic logic addr_hit(input reg_addr_t src, input reg_addr_t dst);
        return (src != {REG_ADDR_W{1'b0}}) && (src == dst);
    endfunction

endpackage

// File: rtl/riscv_hazard_fwd.sv
// Forward select for one ALU operand: picks the youngest in-flight producer
// of the Execute-stage source register.
module riscv_hazard_fwd
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  wr_en_m,
    input  logic                  wr_en_w,
    output logic [1:0]            fwd_sel
);

    logic hit_m_s;
    logic hit_w_s;

    assign hit_m_s = addr_hit(rs_e, rd_m) && wr_en_m;
    assign hit_w_s = addr_hit(rs_e, rd_w) && wr_en_w;

    // Memory stage holds the newer value, so it wins over Writeback.
    always_comb begin
        fwd_sel = FWD_NONE;
        if (hit_m_s) begin
            fwd_sel = FWD_MEM;
        end else if (hit_w_s) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_NONE;
        end
    end

endmodule

// File: rtl/riscv_hazard.sv
// Hazard unit for a 5-stage RISC-V pipeline: operand forwarding, load-use
// stall, branch flush and a saturating count of load-use stall cycles.
module riscv_hazard
    import riscv_pkg::*;
(
    input  logic                   iclk,
    input  logic                   irst,
    input  logic [REG_ADDR_W-1:0]  irs1_d,
    input  logic [REG_ADDR_W-1:0]  irs2_d,
    input  logic [REG_ADDR_W-1:0]  ird_d,
    input  logic                   iresult_srcb0_e,
    input  logic                   ipc_src_e,
    input  logic                   ird_wr_en_1d,
    input  logic                   ird_wr_en_2d,
    output logic                   ostall_f,
    output logic                   ostall_d,
    output logic                   oflush_d,
    output logic                   oflush_e,
    output logic [1:0]             ofwd_a_e,
    output logic [1:0]             ofwd_b_e,
    output logic [STALL_CNT_W-1:0] ostall_cnt
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REG_ADDR_W-1:0]  ADDR_ZERO = {REG_ADDR_W{1'b0}};

    logic [REG_ADDR_W-1:0]  rs1_e_r;
    logic [REG_ADDR_W-1:0]  rs2_e_r;
    logic [REG_ADDR_W-1:0]  rd_e_r;
    logic [REG_ADDR_W-1:0]  rd_m_r;
    logic [REG_ADDR_W-1:0]  rd_w_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    logic       lw_stall_s;
    logic       flush_e_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    // A load in Execute whose destination feeds Decode must wait one cycle,
    // unless a taken branch is about to squash Decode anyway.
    assign lw_stall_s = iresult_srcb0_e
                        && (addr_hit(rd_e_r, irs1_d) || addr_hit(rd_e_r, irs2_d))
                        && !ipc_src_e;
    assign flush_e_s  = lw_stall_s || ipc_src_e;

    riscv_hazard_fwd u_fwd_a (
        .rs_e    (rs1_e_r),
        .rd_m    (rd_m_r),
        .rd_w    (rd_w_r),
        .wr_en_m (ird_wr_en_1d),
        .wr_en_w (ird_wr_en_2d),
        .fwd_sel (fwd_a_s)
    );

    riscv_hazard_fwd u_fwd_b (
        .rs_e    (rs2_e_r),
        .rd_m    (rd_m_r),
        .rd_w    (rd_w_r),
        .wr_en_m (ird_wr_en_1d),
        .wr_en_w (ird_wr_en_2d),
        .fwd_sel (fwd_b_s)
    );

    // Register-address pipeline: advances every cycle, bubble on Execute flush.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            rs1_e_r <= ADDR_ZERO;
            rs2_e_r <= ADDR_ZERO;
            rd_e_r  <= ADDR_ZERO;
            rd_m_r  <= ADDR_ZERO;
            rd_w_r  <= ADDR_ZERO;
        end else begin
            if (flush_e_s) begin
                rs1_e_r <= ADDR_ZERO;
                rs2_e_r <= ADDR_ZERO;
                rd_e_r  <= ADDR_ZERO;
            end else begin
                rs1_e_r <= irs1_d;
                rs2_e_r <= irs2_d;
                rd_e_r  <= ird_d;
            end
            rd_m_r <= rd_e_r;
            rd_w_r <= rd_m_r;
        end
    end

    // Load-use stall counter, pinned at all-ones rather than wrapping.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (lw_stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Hazard outputs follow their inputs immediately; reset forces them low.
    always_comb begin
        ostall_f   = 1'b0;
        ostall_d   = 1'b0;
        oflush_d   = 1'b0;
        oflush_e   = 1'b0;
        ofwd_a_e   = FWD_NONE;
        ofwd_b_e   = FWD_NONE;
        ostall_cnt = {STALL_CNT_W{1'b0}};
        if (irst) begin
            ostall_f   = 1'b0;
            ostall_d   = 1'b0;
            oflush_d   = 1'b0;
            oflush_e   = 1'b0;
            ofwd_a_e   = FWD_NONE;
            ofwd_b_e   = FWD_NONE;
            ostall_cnt = {STALL_CNT_W{1'b0}};
        end else begin
            ostall_f   = lw_stall_s;
            ostall_d   = lw_stall_s;
            oflush_d   = ipc_src_e;
            oflush_e   = flush_e_s;
            ofwd_a_e   = fwd_a_s;
            ofwd_b_e   = fwd_b_s;
            ostall_cnt = stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_riscv_hazard.sv
// Self-checking bench for riscv_hazard: directed vector table, reset and
// saturation sequences, then random traffic against a pipeline-queue model.
module tb_riscv_hazard;

    logic        iclk;
    logic        irst;
    logic [4:0]  irs1_d, irs2_d, ird_d;
    logic        iresult_srcb0_e, ipc_src_e, ird_wr_en_1d, ird_wr_en_2d;
    logic        ostall_f, ostall_d, oflush_d, oflush_e;
    logic [1:0]  ofwd_a_e, ofwd_b_e;
    logic [15:0] ostall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_hazard dut (
        .iclk            (iclk),
        .irst            (irst),
        .irs1_d          (irs1_d),
        .irs2_d          (irs2_d),
        .ird_d           (ird_d),
        .iresult_srcb0_e (iresult_srcb0_e),
        .ipc_src_e       (ipc_src_e),
        .ird_wr_en_1d    (ird_wr_en_1d),
        .ird_wr_en_2d    (ird_wr_en_2d),
        .ostall_f        (ostall_f),
        .ostall_d        (ostall_d),
        .oflush_d        (oflush_d),
        .oflush_e        (oflush_e),
        .ofwd_a_e        (ofwd_a_e),
        .ofwd_b_e        (ofwd_b_e),
        .ostall_cnt      (ostall_cnt)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    typedef struct {
        logic [4:0]  r1, r2, rd;
        logic        ld, pc, w1, w2;
        logic [1:0]  fa, fb;
        logic        st, fd, fe;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int rs1, rs2, rd;
    } ins_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                           input logic st, input logic fd, input logic fe, input logic [15:0] cnt);
        chk({tag, ".fwd_a"},   {14'd0, ofwd_a_e}, {14'd0, fa});
        chk({tag, ".fwd_b"},   {14'd0, ofwd_b_e}, {14'd0, fb});
        chk({tag, ".stall_f"}, {15'd0, ostall_f}, {15'd0, st});
        chk({tag, ".stall_d"}, {15'd0, ostall_d}, {15'd0, st});
        chk({tag, ".flush_d"}, {15'd0, oflush_d}, {15'd0, fd});
        chk({tag, ".flush_e"}, {15'd0, oflush_e}, {15'd0, fe});
        chk({tag, ".cnt"},     ostall_cnt,        cnt);
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic ld, input logic pc, input logic w1, input logic w2);
        irs1_d = r1; irs2_d = r2; ird_d = rd;
        iresult_srcb0_e = ld; ipc_src_e = pc;
        ird_wr_en_1d = w1; ird_wr_en_2d = w2;
    endtask

    function automatic logic [1:0] ref_fwd(input int rs, input int rdm, input int rdw,
                                           input bit w1, input bit w2);
        if (rs != 0 && rs == rdm && w1) return 2'b10;
        if (rs != 0 && rs == rdw && w2) return 2'b01;
        return 2'b00;
    endfunction

    initial begin
        ins_t pipe[$];
        ins_t zero_ins;
        int   cnt_model;

        // Directed table: r1 r2 rd ld pc w1 w2 | fa fb st fd fe cnt
        tbl[0]  = '{5'd0, 5'd0, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{5'd5, 5'd6, 5'd8,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{5'd5, 5'd0, 5'd9,  1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{5'd0, 5'd0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{5'd0, 5'd0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{5'd0, 5'd7, 5'd1,  1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[6]  = '{5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[7]  = '{5'd0, 5'd0, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[8]  = '{5'd4, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 16'd0};
        tbl[9]  = '{5'd4, 5'd3, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[10] = '{5'd3, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[11] = '{5'd0, 5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[12] = '{5'd0, 5'd0, 5'd6,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[13] = '{5'd6, 5'd0, 5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[14] = '{5'd6, 5'd6, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1};

        // Reset state with busy inputs: every output must read zero.
        irst = 1'b1;
        drive(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        chk_all("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge iclk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        irst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge iclk);
            drive(tbl[i].r1, tbl[i].r2, tbl[i].rd, tbl[i].ld, tbl[i].pc, tbl[i].w1, tbl[i].w2);
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].fa, tbl[i].fb, tbl[i].st,
                    tbl[i].fd, tbl[i].fe, tbl[i].cnt);
        end

        // Reset asserted between edges while a flush is showing.
        @(negedge iclk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("pre_rst.flush_d", {15'd0, oflush_d}, 16'd1);
        #1;
        irst = 1'b1;
        #1;
        chk_all("mid_rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge iclk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        irst = 1'b0;
        #1;
        chk("post_rst.fwd_x0", {14'd0, ofwd_a_e}, 16'd0);

        // Saturation: preload near the top, then three load-use stalls.
        @(negedge iclk);
        force dut.stall_cnt_r = 16'hFFFE;
        #1;
        release dut.stall_cnt_r;
        drive(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("sat.preload", ostall_cnt, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            @(negedge iclk);
            #1;
            chk($sformatf("sat%0d.stall", k), {15'd0, ostall_d}, 16'd1);
            chk($sformatf("sat%0d.flush_e", k), {15'd0, oflush_e}, 16'd1);
            @(negedge iclk);
            #1;
            chk($sformatf("sat%0d.bubble", k), {15'd0, ostall_f}, 16'd0);
            chk($sformatf("sat%0d.cnt", k), ostall_cnt, 16'hFFFF);
        end

        // Clean restart for random traffic.
        @(negedge iclk);
        irst = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rnd_rst.cnt", ostall_cnt, 16'd0);
        @(negedge iclk);
        irst = 1'b0;
        zero_ins = '{0, 0, 0};
        pipe = {zero_ins, zero_ins, zero_ins};   // Execute, Memory, Writeback
        cnt_model = 0;

        for (int c = 0; c < 400; c++) begin
            logic [4:0] r1, r2, rd;
            bit ld, pc, w1, w2, st;
            ins_t nxt;
            @(negedge iclk);
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            ld = ($urandom_range(0, 2) == 0);
            pc = ($urandom_range(0, 5) == 0);
            w1 = $urandom_range(0, 1) != 0;
            w2 = $urandom_range(0, 1) != 0;
            drive(r1, r2, rd, ld, pc, w1, w2);
            st = ld && pipe[0].rd != 0 && (pipe[0].rd == int'(r1) || pipe[0].rd == int'(r2)) && !pc;
            #1;
            chk_all($sformatf("rnd%0d", c),
                    ref_fwd(pipe[0].rs1, pipe[1].rd, pipe[2].rd, w1, w2),
                    ref_fwd(pipe[0].rs2, pipe[1].rd, pipe[2].rd, w1, w2),
                    st, pc, st || pc, 16'(cnt_model));
            nxt = (st || pc) ? zero_ins : '{int'(r1), int'(r2), int'(rd)};
            pipe.push_front(nxt);
            void'(pipe.pop_back());
            if (st && cnt_model < 65535) cnt_model++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_hazard.md
RISCV_HAZARD -- requirements
Module: riscv_hazard

Interface
REQ-001: SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002: iclk  input  1  core clock; all state updates on rising edge.
REQ-003: irst  input  1  asynchronous active-high reset.
REQ-004: irs1_d, irs2_d, ird_d  input  5 each  source/destination register addresses of the instruction in Decode.
REQ-005: iresult_srcb0_e  input  1  Execute instruction is a load (result source bit 0 from control).
REQ-006: ipc_src_e  input  1  branch/jump taken, resolved in Execute.
REQ-007: ird_wr_en_1d  input  1  Memory-stage register write enable; ird_wr_en_2d  input  1  Writeback-stage register write enable.
REQ-008: ostall_f, ostall_d  output  1 each  hold PC and Fetch/Decode register.
REQ-009: oflush_d, oflush_e  output  1 each  clear Fetch/Decode register; clear Decode/Execute register (drives control iflush_e).
REQ-010: ofwd_a_e, ofwd_b_e  output  2 each  ALU operand A/B forward select: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-011: ostall_cnt  output  16  saturating count of load-use stall cycles.

Function
REQ-012: Address pipeline: rs1_e/rs2_e/rd_e SHALL capture irs1_d/irs2_d/ird_d each edge, or load 0 when oflush_e=1; rd_m <= rd_e; rd_w <= rd_m.
REQ-013: Address pipeline SHALL have no enables other than flush; it advances every cycle.
REQ-014: ofwd_a_e SHALL be 10 when rs1_e!=0, rs1_e==rd_m and ird_wr_en_1d=1; else 01 when rs1_e!=0, rs1_e==rd_w and ird_wr_en_2d=1; else 00.
REQ-015: ofwd_b_e SHALL follow REQ-014 with rs2_e.
REQ-016: Memory-stage match SHALL take priority over Writeback-stage match when both hit.
REQ-017: Register x0 SHALL never be forwarded, regardless of write enables.
REQ-018: lw_stall SHALL be iresult_srcb0_e & (rd_e!=0) & (rd_e==irs1_d | rd_e==irs2_d) & ~ipc_src_e.
REQ-019: ostall_f = ostall_d = lw_stall.
REQ-020: oflush_d = ipc_src_e; oflush_e = lw_stall | ipc_src_e.
REQ-021: All hazard outputs SHALL be combinational, zero-cycle latency relative to their inputs and registered addresses.
REQ-022: Taken branch coinciding with a load match SHALL suppress the stall; only the flushes assert.
REQ-023: A load-use stall SHALL last exactly one cycle; the bubble inserted into Execute clears rd_e, so lw_stall deasserts next cycle.
REQ-024: ostall_cnt SHALL increment by 1 on each edge where lw_stall=1 and SHALL hold at 16'hFFFF without wrapping.

Reset
REQ-025: irst=1 SHALL immediately clear rs1_e, rs2_e, rd_e, rd_m, rd_w and ostall_cnt to 0, independent of iclk.
REQ-026: While irst=1, all outputs SHALL be 0, regardless of other inputs.
REQ-027: First edge after irst deasserts SHALL behave as normal operation from the cleared state.

Structure
REQ-028: Shared package riscv_pkg SHALL hold REG_ADDR_W=5, FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 and STALL_CNT_W=16.
REQ-029: Forward-select logic SHALL be one sub-module, riscv_hazard_fwd (inputs rs_e, rd_m, rd_w, both write enables; output 2-bit select), instantiated once per operand.

Verification
REQ-030: add x5 in E, then add using rs1=x5 one cycle later with ird_wr_en_1d=1 -> ofwd_a_e=10; next cycle, with ird_wr_en_2d=1 -> 01.
REQ-031: Same rd=x7 in both M and W, both write enables high, rs2_e=x7 -> ofwd_b_e=10.
REQ-032: lw x3 in E (iresult_srcb0_e=1, rd_e=3) and irs2_d=3 -> ostall_f=ostall_d=oflush_e=1 for exactly one cycle, ostall_cnt 0->1; lw x0 with irs1_d=0 -> no stall.
REQ-033: ipc_src_e=1 with a simultaneous load match -> oflush_d=oflush_e=1, ostall_f=ostall_d=0, ostall_cnt unchanged; next cycle rs1_e=rs2_e=rd_e=0.
REQ-034: Preload ostall_cnt to 16'hFFFE, then three stall cycles -> ostall_cnt=16'hFFFF, held.
REQ-035: Assert irst mid-sequence between clock edges -> all outputs 0 immediately; addresses and ostall_cnt 0; rd_x0 forwarding with ird_wr_en_1d=1 -> 00.
